e_mdu: RTL and testbench

Execute-stage multiply/divide unit for the five-stage MIPS pipeline. It consumes the decoded MDU control code and start strobe after they travel through the D/E pipeline register, together with the forwarded rs/rt operands. It performs mult/multu/div/divu with fixed multi-cycle latency into private HI/LO registers, services mthi/mtlo/mfhi/mflo, and reports busy so the hazard logic can stall MDU-class instructions in D.

---
 rtl/e_mdu_pkg.sv | 20 ++
 rtl/e_mdu.sv | 103 ++++++++++
 tb/tb_e_mdu.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/e_mdu_pkg.sv
// Shared MDU definitions: operation codes as decoded in D, and default latencies.
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    localparam int unsigned MULT_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF  = 10;
    localparam int unsigned CNT_W        = 4;

endpackage

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: fixed-latency mult/div into private HI/LO,
// plus mthi/mtlo/mfhi/mflo and a busy flag for the D-stage hazard logic.
module e_mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDU_Ctr,
    input  logic        E_start,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    output logic        E_MDU_busy,
    output logic [31:0] E_MDU_out,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO
);

    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      hi_q, lo_q, pend_hi_q, pend_lo_q;
    logic             pend_we_q;

    logic [31:0]      pend_hi_d, pend_lo_d;
    logic             pend_we_d;
    logic [CNT_W-1:0] cnt_load;
    logic             is_mult, is_div, sgn, a_neg, b_neg, busy;
    logic [63:0]      mul_a, mul_b, prod;
    logic [31:0]      dvd, dvs, dvs_safe, q_mag, r_mag;

    assign busy = (cnt_q != '0);

    always_comb begin
        is_mult = (E_MDU_Ctr == MDU_MULT) || (E_MDU_Ctr == MDU_MULTU);
        is_div  = (E_MDU_Ctr == MDU_DIV)  || (E_MDU_Ctr == MDU_DIVU);
        sgn     = (E_MDU_Ctr == MDU_MULT) || (E_MDU_Ctr == MDU_DIV);

        mul_a = sgn ? {{32{E_A[31]}}, E_A} : {32'b0, E_A};
        mul_b = sgn ? {{32{E_B[31]}}, E_B} : {32'b0, E_B};
        prod  = mul_a * mul_b;

        // Signed divide via magnitudes avoids the INT_MIN / -1 overflow trap;
        // negating 0x80000000 wraps back to itself, which is the required result.
        a_neg    = sgn & E_A[31];
        b_neg    = sgn & E_B[31];
        dvd      = a_neg ? -E_A : E_A;
        dvs      = b_neg ? -E_B : E_B;
        dvs_safe = (dvs == '0) ? 32'd1 : dvs;
        q_mag    = dvd / dvs_safe;
        r_mag    = dvd % dvs_safe;

        pend_hi_d = prod[63:32];
        pend_lo_d = prod[31:0];
        pend_we_d = 1'b1;
        cnt_load  = CNT_W'(MULT_LAT);
        if (is_div) begin
            pend_lo_d = (a_neg ^ b_neg) ? -q_mag : q_mag;
            pend_hi_d = a_neg ? -r_mag : r_mag;
            pend_we_d = (E_B != '0);
            cnt_load  = CNT_W'(DIV_LAT);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_we_q <= 1'b0;
        end else if (busy) begin
            cnt_q <= cnt_q - 1'b1;
            if ((cnt_q == CNT_W'(1)) && pend_we_q) begin
                hi_q <= pend_hi_q;
                lo_q <= pend_lo_q;
            end
        end else if (E_start) begin
            if (is_mult || is_div) begin
                cnt_q     <= cnt_load;
                pend_hi_q <= pend_hi_d;
                pend_lo_q <= pend_lo_d;
                pend_we_q <= pend_we_d;
            end
        end else if (E_MDU_Ctr == MDU_MTHI) begin
            hi_q <= E_A;
        end else if (E_MDU_Ctr == MDU_MTLO) begin
            lo_q <= E_A;
        end
    end

    always_comb begin
        E_MDU_out = '0;
        if (E_MDU_Ctr == MDU_MFHI)      E_MDU_out = hi_q;
        else if (E_MDU_Ctr == MDU_MFLO) E_MDU_out = lo_q;
    end

    assign E_MDU_busy = busy;
    assign E_HI       = hi_q;
    assign E_LO       = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: expected HI/LO queued at each start, checked when busy drops.
module tb_e_mdu;
    import mdu_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  E_MDU_Ctr;
    logic        E_start;
    logic [31:0] E_A, E_B;
    logic        E_MDU_busy;
    logic [31:0] E_MDU_out, E_HI, E_LO;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   proto_err = 0;

    e_mdu #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .E_MDU_Ctr  (E_MDU_Ctr),
        .E_start    (E_start),
        .E_A        (E_A),
        .E_B        (E_B),
        .E_MDU_busy (E_MDU_busy),
        .E_MDU_out  (E_MDU_out),
        .E_HI       (E_HI),
        .E_LO       (E_LO)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (E_start === 1'b1 && E_MDU_busy === 1'b1) begin
            proto_err <= proto_err + 1;
            $display("note: protocol violation, start while busy at %0t", $time);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        else passes++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Start an op, measure busy length, then pop the scoreboard and compare HI/LO.
    task automatic run_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input string nm);
        int cycles;
        exp_t e;
        E_MDU_Ctr = code; E_A = a; E_B = b; E_start = 1'b1;
        tick();
        E_start = 1'b0; E_MDU_Ctr = MDU_NONE;
        cycles = (E_MDU_busy === 1'b1) ? 1 : 0;
        while (E_MDU_busy === 1'b1 && cycles < 40) begin
            tick();
            if (E_MDU_busy === 1'b1) cycles++;
        end
        chk({nm, "_busy_len"}, 32'(cycles), 32'(lat));
        if (sb.size() == 0) begin
            checks++;
            $display("FAIL %s_sb: got empty queue expected entry", nm);
        end else begin
            e = sb.pop_front();
            chk({e.name, "_hi"}, E_HI, e.hi);
            chk({e.name, "_lo"}, E_LO, e.lo);
            E_MDU_Ctr = MDU_MFHI; #1;
            chk({e.name, "_mfhi"}, E_MDU_out, e.hi);
            E_MDU_Ctr = MDU_MFLO; #1;
            chk({e.name, "_mflo"}, E_MDU_out, e.lo);
            E_MDU_Ctr = MDU_NONE;
        end
    endtask

    task automatic push(input logic [31:0] hi, input logic [31:0] lo, input string nm);
        exp_t e;
        e.hi = hi; e.lo = lo; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        do_reset();
        chk("rst_busy", 32'(E_MDU_busy), 32'd0);
        chk("rst_hi", E_HI, 32'h0);
        chk("rst_lo", E_LO, 32'h0);
        E_MDU_Ctr = MDU_MFHI; #1;
        chk("rst_out", E_MDU_out, 32'h0);
        E_MDU_Ctr = MDU_NONE;
    endtask

    task automatic test_mult();
        push(32'hFFFFFFFF, 32'hFFFFFFFA, "mult");
        run_op(MDU_MULT, 32'hFFFFFFFE, 32'd3, 5, "mult");
        push(32'h00000002, 32'hFFFFFFFA, "multu");
        run_op(MDU_MULTU, 32'hFFFFFFFE, 32'd3, 5, "multu");
    endtask

    task automatic test_div();
        push(32'hFFFFFFFF, 32'hFFFFFFFD, "div");
        run_op(MDU_DIV, 32'hFFFFFFF9, 32'd2, 10, "div");
        push(32'h00000001, 32'h7FFFFFFC, "divu");
        run_op(MDU_DIVU, 32'hFFFFFFF9, 32'd2, 10, "divu");
        push(32'h00000000, 32'h80000000, "div_ovf");
        run_op(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 10, "div_ovf");
    endtask

    task automatic test_mthi_divzero();
        do_reset();
        E_MDU_Ctr = MDU_MTHI; E_A = 32'h12345678;
        tick();
        E_MDU_Ctr = MDU_MFLO; #1;
        chk("mflo_after_mthi", E_MDU_out, 32'h0);
        tick();
        E_MDU_Ctr = MDU_MFHI; #1;
        chk("mfhi_after_mthi", E_MDU_out, 32'h12345678);
        E_MDU_Ctr = MDU_NONE;
        push(32'h12345678, 32'h0, "divu_zero");
        run_op(MDU_DIVU, 32'd99, 32'd0, 10, "divu_zero");
    endtask

    task automatic test_reset_midrun();
        E_MDU_Ctr = MDU_MTLO; E_A = 32'hCAFEF00D;
        tick();
        E_MDU_Ctr = MDU_DIV; E_A = 32'd100; E_B = 32'd7; E_start = 1'b1;
        tick();
        E_start = 1'b0; E_MDU_Ctr = MDU_NONE;
        tick(); tick(); tick();
        chk("mid_busy_before_rst", 32'(E_MDU_busy), 32'd1);
        do_reset();
        chk("mid_busy", 32'(E_MDU_busy), 32'd0);
        chk("mid_hi", E_HI, 32'h0);
        chk("mid_lo", E_LO, 32'h0);
        for (int i = 0; i < 12; i++) tick();
        chk("mid_lo_stays", E_LO, 32'h0);
        E_MDU_Ctr = MDU_MFHI; #1;
        chk("mid_mfhi", E_MDU_out, 32'h0);
        E_MDU_Ctr = MDU_NONE;
    endtask

    task automatic test_back_to_back();
        int cycles;
        exp_t e;
        push(32'h0, 32'd42, "proto");
        E_MDU_Ctr = MDU_MULT; E_A = 32'd7; E_B = 32'd6; E_start = 1'b1;
        tick();
        E_start = 1'b0; E_MDU_Ctr = MDU_NONE;
        cycles = 1;
        tick(); cycles++;
        E_MDU_Ctr = MDU_MULTU; E_A = 32'd3; E_B = 32'd3; E_start = 1'b1;
        tick(); cycles++;
        E_start = 1'b0; E_MDU_Ctr = MDU_MTHI; E_A = 32'h0000DEAD;
        tick(); cycles++;
        E_MDU_Ctr = MDU_NONE;
        chk("proto_mthi_ignored", E_HI, 32'h0);
        while (E_MDU_busy === 1'b1 && cycles < 40) begin
            tick();
            if (E_MDU_busy === 1'b1) cycles++;
        end
        chk("proto_busy_len", 32'(cycles), 32'd5);
        e = sb.pop_front();
        chk("proto_hi", E_HI, e.hi);
        chk("proto_lo", E_LO, e.lo);
        chk("proto_flag", 32'(proto_err), 32'd1);
    endtask

    initial begin
        reset = 1'b0; E_MDU_Ctr = MDU_NONE; E_start = 1'b0; E_A = '0; E_B = '0;
        tick();
        test_reset();
        test_mult();
        test_div();
        test_mthi_divzero();
        test_reset_midrun();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
